ita_tile_sequencer: RTL and testbench

// Issues one compute beat per (outer tile, inner tile) pair into the ITA dot-product pipeline.

---
 rtl/ita_tile_sequencer_pkg.sv | 24 ++
 rtl/ita_tile_sequencer_credit_counter.sv | 47 ++++
 rtl/ita_tile_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ita_tile_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_tile_sequencer_pkg.sv
// Shared types and defaults for the ITA tile sequencer and its credit counter.
// No logic; constants, the sequencer state encoding and a credit-width helper.
// Defaults here are the parameter defaults of the top; instances may override.
package ita_tile_sequencer_pkg;

    localparam int unsigned FifoDepthDef = 12;
    localparam int unsigned PipeLatDef   = 8;
    localparam int unsigned TileCntWDef  = 10;

    typedef enum logic [1:0] {
        SeqIdle  = 2'd0,
        SeqRun   = 2'd1,
        SeqDrain = 2'd2
    } seq_state_e;

    typedef logic [TileCntWDef-1:0]            tile_cnt_t;
    typedef logic [$clog2(FifoDepthDef+1)-1:0] credit_t;

    // Wide enough to hold every value 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ita_tile_sequencer_credit_counter.sv
// Saturating credit counter guarding the output FIFO; resets to Depth credits.
// Latency: count updates one cycle after consume_i / return_i; has_credit_o is a
// registered-state decode. Backpressure: consumer must not consume at zero credits.
// Ports: clk_i, rst_i (sync, active-high), consume_i, return_i, credits_o, has_credit_o.
module ita_tile_sequencer_credit_counter
    import ita_tile_sequencer_pkg::*;
#(
    parameter  int unsigned Depth   = FifoDepthDef,
    localparam int unsigned CreditW = credit_width(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               consume_i,
    input  logic               return_i,
    output logic [CreditW-1:0] credits_o,
    output logic               has_credit_o
);

    logic [CreditW-1:0] credits_d;
    logic [CreditW-1:0] credits_q;

    // Simultaneous consume and return cancel out; otherwise clamp at both ends.
    always_comb begin
        credits_d = credits_q;
        if (consume_i && !return_i) begin
            if (credits_q != '0) begin
                credits_d = credits_q - CreditW'(1);
            end
        end else if (return_i && !consume_i) begin
            if (credits_q != CreditW'(Depth)) begin
                credits_d = credits_q + CreditW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q <= CreditW'(Depth);
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits_o    = credits_q;
    assign has_credit_o = (credits_q != '0);

endmodule

// File: rtl/ita_tile_sequencer.sv
// Issues one compute beat per (outer, inner) tile pair, joining input/weight/bias streams.
// Latency: readies combinational with the issue; beat outputs registered one cycle later;
// done_o PipeLat cycles after the final beat. Backpressure: stalls on missing valids or,
// for the last inner tile, on zero output-FIFO credits.
// Ports: clk_i, rst_i, start_i, n_inner_i, n_outer_i, {inp,weight,bias}_{valid_i,ready_o},
// fifo_pop_i, calc_en_o, first_inner_tile_o, last_inner_tile_o, outer_idx_o, busy_o, done_o.
module ita_tile_sequencer
    import ita_tile_sequencer_pkg::*;
#(
    parameter int unsigned FifoDepth = FifoDepthDef,
    parameter int unsigned PipeLat   = PipeLatDef,
    parameter int unsigned TileCntW  = TileCntWDef
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [TileCntW-1:0] n_inner_i,
    input  logic [TileCntW-1:0] n_outer_i,
    input  logic                inp_valid_i,
    output logic                inp_ready_o,
    input  logic                weight_valid_i,
    output logic                weight_ready_o,
    input  logic                bias_valid_i,
    output logic                bias_ready_o,
    input  logic                fifo_pop_i,
    output logic                calc_en_o,
    output logic                first_inner_tile_o,
    output logic                last_inner_tile_o,
    output logic [TileCntW-1:0] outer_idx_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned CreditW = credit_width(FifoDepth);
    localparam int unsigned DrainW  = $clog2(PipeLat + 1);

    seq_state_e          state_d, state_q;
    logic [TileCntW-1:0] n_inner_d, n_inner_q;
    logic [TileCntW-1:0] n_outer_d, n_outer_q;
    logic [TileCntW-1:0] inner_d, inner_q;
    logic [TileCntW-1:0] outer_d, outer_q;
    logic [TileCntW-1:0] outer_idx_d, outer_idx_q;
    logic [DrainW-1:0]   drain_d, drain_q;
    logic                calc_en_d, calc_en_q;
    logic                first_d, first_q;
    logic                last_d, last_q;
    logic                done_d, done_q;

    logic                is_first, is_last, is_final_outer, issue;
    logic                has_credit, credit_consume;
    logic [CreditW-1:0]  credits;

    assign is_first       = (inner_q == '0);
    assign is_last        = (inner_q == n_inner_q - TileCntW'(1));
    assign is_final_outer = (outer_q == n_outer_q - TileCntW'(1));

    // Bias is only needed at the start of an output tile; a credit is only needed
    // at the end, since that beat is the one that eventually pushes into the FIFO.
    assign issue = (state_q == SeqRun) && inp_valid_i && weight_valid_i
                && (bias_valid_i || !is_first) && (has_credit || !is_last);

    assign credit_consume = issue && is_last;

    ita_tile_sequencer_credit_counter #(
        .Depth (FifoDepth)
    ) u_credit (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .consume_i    (credit_consume),
        .return_i     (fifo_pop_i),
        .credits_o    (credits),
        .has_credit_o (has_credit)
    );

    always_comb begin
        state_d     = state_q;
        n_inner_d   = n_inner_q;
        n_outer_d   = n_outer_q;
        inner_d     = inner_q;
        outer_d     = outer_q;
        outer_idx_d = outer_idx_q;
        drain_d     = drain_q;
        calc_en_d   = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            SeqIdle: begin
                if (start_i) begin
                    if ((n_inner_i != '0) && (n_outer_i != '0)) begin
                        n_inner_d = n_inner_i;
                        n_outer_d = n_outer_i;
                        inner_d   = '0;
                        outer_d   = '0;
                        state_d   = SeqRun;
                    end else begin
                        // Empty job: complete immediately without issuing anything.
                        done_d = 1'b1;
                    end
                end
            end
            SeqRun: begin
                if (issue) begin
                    calc_en_d   = 1'b1;
                    first_d     = is_first;
                    last_d      = is_last;
                    outer_idx_d = outer_q;
                    if (is_last) begin
                        inner_d = '0;
                        if (is_final_outer) begin
                            drain_d = '0;
                            state_d = SeqDrain;
                        end else begin
                            outer_d = outer_q + TileCntW'(1);
                        end
                    end else begin
                        inner_d = inner_q + TileCntW'(1);
                    end
                end
            end
            SeqDrain: begin
                // Wait out the pipeline so done_o lines up with the final FIFO push.
                if (drain_q == DrainW'(PipeLat - 1)) begin
                    done_d  = 1'b1;
                    state_d = SeqIdle;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            default: state_d = SeqIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SeqIdle;
            n_inner_q   <= '0;
            n_outer_q   <= '0;
            inner_q     <= '0;
            outer_q     <= '0;
            outer_idx_q <= '0;
            drain_q     <= '0;
            calc_en_q   <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_inner_q   <= n_inner_d;
            n_outer_q   <= n_outer_d;
            inner_q     <= inner_d;
            outer_q     <= outer_d;
            outer_idx_q <= outer_idx_d;
            drain_q     <= drain_d;
            calc_en_q   <= calc_en_d;
            first_q     <= first_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign inp_ready_o        = issue;
    assign weight_ready_o     = issue;
    assign bias_ready_o       = issue && is_first;
    assign calc_en_o          = calc_en_q;
    assign first_inner_tile_o = first_q;
    assign last_inner_tile_o  = last_q;
    assign outer_idx_o        = outer_idx_q;
    assign busy_o             = (state_q != SeqIdle);
    assign done_o             = done_q;

    // A pop that would push the count above FifoDepth means the FIFO returned a
    // credit it never received; the counter clamps, but the system is broken.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_pop_i && !credit_consume && (credits == CreditW'(FifoDepth))));

endmodule

// File: tb/tb_ita_tile_sequencer.sv
module tb_ita_tile_sequencer;

    localparam int FD = 2;
    localparam int PL = 8;
    localparam int TW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] n_inner, n_outer;
    logic          inp_valid, inp_ready;
    logic          weight_valid, weight_ready;
    logic          bias_valid, bias_ready;
    logic          fifo_pop, man_pop, auto_pop;
    logic          calc_en, first_t, last_t;
    logic [TW-1:0] outer_idx;
    logic          busy, done;
    logic [1:0]    cr;

    always #5 clk = ~clk;

    ita_tile_sequencer #(
        .FifoDepth (FD),
        .PipeLat   (PL),
        .TileCntW  (TW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .n_inner_i          (n_inner),
        .n_outer_i          (n_outer),
        .inp_valid_i        (inp_valid),
        .inp_ready_o        (inp_ready),
        .weight_valid_i     (weight_valid),
        .weight_ready_o     (weight_ready),
        .bias_valid_i       (bias_valid),
        .bias_ready_o       (bias_ready),
        .fifo_pop_i         (fifo_pop),
        .calc_en_o          (calc_en),
        .first_inner_tile_o (first_t),
        .last_inner_tile_o  (last_t),
        .outer_idx_o        (outer_idx),
        .busy_o             (busy),
        .done_o             (done)
    );

    assign cr = dut.u_credit.credits_o;
    // The FIFO stand-in pops only when it holds something, i.e. a credit is out.
    assign fifo_pop = man_pop | (auto_pop & (int'(cr) < FD));

    typedef struct {
        int   cyc;
        logic first;
        logic last;
        int   outer;
    } beat_t;

    typedef struct {
        logic pop, iv, wv, bv;
        logic exp_ir, exp_br;
        int   exp_cr;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    beat_t      beats[$];
    int         done_cyc[$];
    logic [1:0] iss[$];
    logic       viol;
    vec_t       tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycle monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (calc_en) beats.push_back('{cyc, first_t, last_t, int'(outer_idx)});
            if (done) begin
                done_cyc.push_back(cyc);
                chk("busy_low_at_done", int'(busy), 0);
            end
            if (inp_ready || weight_ready || bias_ready) begin
                viol = (inp_ready && !(inp_valid && weight_valid))
                    || (weight_ready != inp_ready)
                    || (bias_ready && !(bias_valid && inp_ready));
                chk("ready_needs_valids", int'(viol), 0);
                if (inp_ready) iss.push_back({bias_ready, bias_valid});
            end
        end
    end

    task automatic clear_logs();
        beats.delete();
        done_cyc.delete();
        iss.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; n_inner = '0; n_outer = '0;
        inp_valid = 1'b0; weight_valid = 1'b0; bias_valid = 1'b0;
        man_pop = 1'b0; auto_pop = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_calc_en", int'(calc_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_credits", int'(cr), FD);
        chk("rst_outer_idx", int'(outer_idx), 0);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic start_job(input int ni, input int no);
        @(posedge clk); #1;
        start = 1'b1; n_inner = TW'(ni); n_outer = TW'(no);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: hold inputs; 1: toggle bias; 2: random inp/weight; 3: hold + stray start.
    task automatic run_until_done(input int budget, input int mode);
        for (int c = 0; c < budget && done_cyc.size() == 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (mode)
                1: bias_valid = ~bias_valid;
                2: begin
                    inp_valid    = 1'($urandom_range(0, 1));
                    weight_valid = 1'($urandom_range(0, 1));
                end
                3: if (c == 3) begin
                    start = 1'b1; n_inner = TW'(1); n_outer = TW'(1);
                end
                default: ;
            endcase
        end
        chk("done_seen", done_cyc.size(), 1);
    endtask

    task automatic check_beats(input int ni, input int no, input bit consec);
        int errs = 0;
        chk("beat_count", beats.size(), ni * no);
        for (int i = 0; i < beats.size() && i < ni * no; i++) begin
            if (beats[i].first != (i % ni == 0)) errs++;
            if (beats[i].last != (i % ni == ni - 1)) errs++;
            if (beats[i].outer != i / ni) errs++;
            if (consec && beats[i].cyc != beats[0].cyc + i) errs++;
        end
        chk("beat_order", errs, 0);
    endtask

    task automatic check_done_lat();
        if (done_cyc.size() > 0 && beats.size() > 0)
            chk("done_latency", done_cyc[0] - beats[beats.size()-1].cyc, PL);
        else
            chk("done_latency_seen", 0, 1);
    endtask

    initial begin
        // n_inner=2, n_outer=3, FifoDepth=2, credits only returned by explicit pops.
        //            pop iv wv bv  ir br cr
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2}; // first tile, no bias
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2}; // weight missing
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2}; // input missing
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2}; // beat (0,0)
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2}; // beat (0,1) no bias needed
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1}; // first of outer 1, no bias
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1}; // beat (1,0)
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1}; // input gap
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1}; // beat (1,1) uses last credit
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0}; // first tile needs no credit
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0}; // last tile, no credit
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0}; // still stalled
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0}; // pop lands next cycle
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1}; // final beat (2,1)

        // Table-driven issue/ready/credit checks.
        do_reset();
        start_job(2, 3);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            man_pop = tbl[i].pop; inp_valid = tbl[i].iv;
            weight_valid = tbl[i].wv; bias_valid = tbl[i].bv;
            #3;
            chk($sformatf("vec%0d_inp_ready", i), int'(inp_ready), int'(tbl[i].exp_ir));
            chk($sformatf("vec%0d_bias_ready", i), int'(bias_ready), int'(tbl[i].exp_br));
            chk($sformatf("vec%0d_credits", i), int'(cr), tbl[i].exp_cr);
        end
        @(posedge clk); #1;
        man_pop = 1'b0; inp_valid = 1'b0; weight_valid = 1'b0; bias_valid = 1'b0;
        run_until_done(40, 0);
        check_beats(2, 3, 1'b0);
        check_done_lat();

        // Full throughput 4x3; a stray start mid-job must be ignored.
        do_reset();
        inp_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b1; auto_pop = 1'b1;
        start_job(4, 3);
        #3 chk("busy_after_start", int'(busy), 1);
        run_until_done(60, 3);
        check_beats(4, 3, 1'b1);
        check_done_lat();

        // Credit stall: no pops, two credits. Beat 11 (last tile of outer 2) waits.
        do_reset();
        inp_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b1;
        start_job(4, 3);
        repeat (30) @(posedge clk);
        #1;
        chk("stall_beats", beats.size(), 11);
        chk("stall_no_done", done_cyc.size(), 0);
        chk("stall_busy", int'(busy), 1);
        man_pop = 1'b1;
        @(posedge clk); #1;
        man_pop = 1'b0;
        run_until_done(40, 0);
        check_beats(4, 3, 1'b0);
        check_done_lat();

        // n_inner=1: every beat takes bias and a credit; bias toggles.
        do_reset();
        inp_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b0; auto_pop = 1'b1;
        start_job(1, 5);
        run_until_done(100, 1);
        check_beats(1, 5, 1'b0);
        begin
            int errs = 0;
            chk("n1_issue_count", iss.size(), 5);
            foreach (iss[k]) if (iss[k] != 2'b11) errs++;
            chk("n1_bias_ready_eq_inp_ready", errs, 0);
        end

        // Random input/weight gaps.
        do_reset();
        bias_valid = 1'b1; auto_pop = 1'b1;
        start_job(4, 3);
        run_until_done(2000, 2);
        check_beats(4, 3, 1'b0);
        check_done_lat();

        // Consume and pop in the same cycle.
        do_reset();
        start_job(1, 3);
        @(posedge clk); #1;
        inp_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b1;
        #3;
        chk("cp_issue0", int'(inp_ready), 1);
        chk("cp_credits0", int'(cr), 2);
        @(posedge clk); #1;
        man_pop = 1'b1;
        #3;
        chk("cp_issue1_with_pop", int'(inp_ready), 1);
        chk("cp_credits1", int'(cr), 1);
        @(posedge clk); #1;
        man_pop = 1'b0; inp_valid = 1'b0; weight_valid = 1'b0;
        #3;
        chk("cp_credits_unchanged", int'(cr), 1);
        auto_pop = 1'b1; inp_valid = 1'b1; weight_valid = 1'b1;
        run_until_done(50, 0);
        check_beats(1, 3, 1'b0);

        // Empty job: done one cycle after start, no beats.
        do_reset();
        inp_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b1;
        start_job(3, 0);
        #3;
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        @(posedge clk); #4;
        chk("zero_done_pulse", int'(done), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("zero_no_beats", beats.size(), 0);
        chk("zero_done_count", done_cyc.size(), 1);

        // Reset in the middle of a job, then a clean rerun.
        do_reset();
        inp_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b1;
        start_job(4, 3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_credits", int'(cr), FD);
        chk("midrst_calc_en", int'(calc_en), 0);
        clear_logs();
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cyc.size(), 0);
        chk("midrst_no_beats", beats.size(), 0);
        auto_pop = 1'b1;
        start_job(2, 2);
        run_until_done(40, 0);
        check_beats(2, 2, 1'b1);
        check_done_lat();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
